// File: rtl/tdm_pkg.sv
// tdm_pkg: shared state encoding and default sizes for the TDM demultiplexer.
package tdm_pkg;
   typedef enum logic {HUNT, SYNC} state_t;
   localparam int NCH_DEF = 4;
   localparam int W_DEF = 8;
   localparam int ERR_W = 8;
endpackage

// File: rtl/tdm_demux_if.sv
// tdm_demux_if: shared slot-word stream feeding the demultiplexer.
interface tdm_demux_if
   import tdm_pkg::*;
#(
   parameter int W = W_DEF
);
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_sof;
   modport master (output in_valid, in_data, in_sof);
   modport slave (input in_valid, in_data, in_sof);
endinterface

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: slot counter with clear, load-1, increment-with-wrap and terminal flag.
module tdm_slot_ctr #(
   parameter int NCH = 4,
   localparam int SW = $clog2(NCH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          ld1,
   input  logic          inc,
   output logic [SW-1:0] slot,
   output logic          last
);
   assign last = slot == SW'(NCH - 1);
   always_ff @(posedge clk)
      if (rst || clr) slot <= '0;
      else if (ld1) slot <= SW'(1);
      else if (inc) slot <= last ? '0 : slot + SW'(1);
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: locks onto frame SOF, steers slot words to channel registers, flags framing errors.
// TDM_DEMUX_ERR_CNT_EN adds a saturating framing-error counter port err_cnt.
module tdm_demux
   import tdm_pkg::*;
#(
   parameter int NCH = NCH_DEF,
   parameter int W = W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   tdm_demux_if.slave            bus,
   output logic [NCH-1:0][W-1:0] ch_data,
   output logic [NCH-1:0]        ch_valid,
   output logic                  frame_done,
   output logic                  sync,
   output logic                  sof_err
`ifdef TDM_DEMUX_ERR_CNT_EN
   ,
   output logic [ERR_W-1:0]      err_cnt
`endif
);
   localparam int SW = $clog2(NCH);
   state_t state, state_nxt;
   logic [SW-1:0] slot, widx;
   logic last, wr, ld1, clr, inc, err, done;
   tdm_slot_ctr #(.NCH(NCH)) u_ctr (
      .clk(clk), .rst(rst), .clr(clr), .ld1(ld1), .inc(inc), .slot(slot), .last(last)
   );
   always_comb begin
      state_nxt = state;
      wr = 1'b0;
      ld1 = 1'b0;
      clr = 1'b0;
      inc = 1'b0;
      err = 1'b0;
      done = 1'b0;
      if (bus.in_valid) begin
         if (state == HUNT) begin
            if (bus.in_sof) begin
               wr = 1'b1;
               ld1 = 1'b1;
               state_nxt = SYNC;
            end
         end else if (bus.in_sof && slot != '0) begin
            err = 1'b1;
            wr = 1'b1;
            ld1 = 1'b1;
         end else if (!bus.in_sof && slot == '0) begin
            err = 1'b1;
            clr = 1'b1;
            state_nxt = HUNT;
         end else begin
            wr = 1'b1;
            inc = 1'b1;
            done = last;
         end
      end
   end
   // an SOF beat always lands in slot 0 regardless of the current count
   assign widx = ld1 ? '0 : slot;
   assign sync = state == SYNC;
   always_ff @(posedge clk)
      if (rst) begin
         state <= HUNT;
         ch_data <= '0;
         ch_valid <= '0;
         frame_done <= 1'b0;
         sof_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (wr) ch_data[widx] <= bus.in_data;
         ch_valid <= wr ? {{(NCH-1){1'b0}}, 1'b1} << widx : '0;
         frame_done <= done;
         sof_err <= err;
      end
`ifdef TDM_DEMUX_ERR_CNT_EN
   always_ff @(posedge clk)
      if (rst) err_cnt <= '0;
      else if (err && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
`endif
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: table vectors, hand sequences and random stimulus against a frame-level model.
module tb_tdm_demux;
   import tdm_pkg::*;
   localparam int NCH = 4;
   localparam int W = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   tdm_demux_if #(.W(W)) bus();
   logic [NCH-1:0][W-1:0] ch_data;
   logic [NCH-1:0] ch_valid;
   logic frame_done, sync, sof_err;
`ifdef TDM_DEMUX_ERR_CNT_EN
   logic [7:0] err_cnt;
`endif
   tdm_demux #(.NCH(NCH), .W(W)) dut (
      .clk(clk), .rst(rst), .bus(bus), .ch_data(ch_data), .ch_valid(ch_valid),
      .frame_done(frame_done), .sync(sync), .sof_err(sof_err)
`ifdef TDM_DEMUX_ERR_CNT_EN
      , .err_cnt(err_cnt)
`endif
   );
   int vectors = 0;
   int miscompares = 0;
   logic [NCH-1:0][W-1:0] m_data = '0;
   logic [NCH-1:0] m_valid = '0;
   bit m_done = 0, m_err = 0, m_locked = 0;
   int m_slot = 0, m_cnt = 0;
   typedef struct {
      bit r, v, s;
      logic [7:0] d;
      logic [31:0] data;
      logic [3:0] vld;
      bit done, sy, err;
   } vec_t;
   vec_t tbl[14];

   task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask

   // frame-level behaviour: lock flag plus position within the current frame
   task automatic model(input bit r, input bit v, input bit s, input logic [W-1:0] d);
      m_valid = '0;
      m_done = 0;
      m_err = 0;
      if (r) begin
         m_data = '0;
         m_locked = 0;
         m_slot = 0;
         m_cnt = 0;
      end else if (v) begin
         if (!m_locked) begin
            if (s) begin
               m_data[0] = d;
               m_valid[0] = 1'b1;
               m_locked = 1;
               m_slot = 1;
            end
         end else if (s && m_slot != 0) begin
            m_err = 1;
            m_data[0] = d;
            m_valid[0] = 1'b1;
            m_slot = 1;
         end else if (!s && m_slot == 0) begin
            m_err = 1;
            m_locked = 0;
         end else begin
            m_data[m_slot] = d;
            m_valid[m_slot] = 1'b1;
            if (m_slot == NCH - 1) begin
               m_done = 1;
               m_slot = 0;
            end else m_slot++;
         end
         if (m_err && m_cnt < 255) m_cnt++;
      end
   endtask

   task automatic step(input bit r, input bit v, input bit s, input logic [W-1:0] d);
      rst = r;
      bus.in_valid = v;
      bus.in_sof = s;
      bus.in_data = d;
      @(posedge clk);
      model(r, v, s, d);
      #1;
      check("ch_data", 64'(ch_data), 64'(m_data));
      check("ch_valid", 64'(ch_valid), 64'(m_valid));
      check("frame_done", 64'(frame_done), 64'(m_done));
      check("sync", 64'(sync), 64'(m_locked));
      check("sof_err", 64'(sof_err), 64'(m_err));
`ifdef TDM_DEMUX_ERR_CNT_EN
      check("err_cnt", 64'(err_cnt), 64'(m_cnt));
`endif
   endtask

   initial begin
      tbl[0]  = '{1, 0, 0, 8'h00, 32'h00000000, 4'h0, 0, 0, 0};
      tbl[1]  = '{0, 1, 1, 8'h11, 32'h00000011, 4'h1, 0, 1, 0};
      tbl[2]  = '{0, 1, 0, 8'h22, 32'h00002211, 4'h2, 0, 1, 0};
      tbl[3]  = '{0, 1, 0, 8'h33, 32'h00332211, 4'h4, 0, 1, 0};
      tbl[4]  = '{0, 1, 0, 8'h44, 32'h44332211, 4'h8, 1, 1, 0};
      tbl[5]  = '{0, 0, 0, 8'hE1, 32'h44332211, 4'h0, 0, 1, 0};
      tbl[6]  = '{0, 1, 0, 8'h77, 32'h44332211, 4'h0, 0, 0, 1};
      tbl[7]  = '{0, 1, 0, 8'hAA, 32'h44332211, 4'h0, 0, 0, 0};
      tbl[8]  = '{0, 1, 0, 8'hBB, 32'h44332211, 4'h0, 0, 0, 0};
      tbl[9]  = '{0, 1, 1, 8'h01, 32'h44332201, 4'h1, 0, 1, 0};
      tbl[10] = '{0, 1, 0, 8'h02, 32'h44330201, 4'h2, 0, 1, 0};
      tbl[11] = '{0, 1, 1, 8'h55, 32'h44330255, 4'h1, 0, 1, 1};
      tbl[12] = '{0, 1, 0, 8'h66, 32'h44336655, 4'h2, 0, 1, 0};
      tbl[13] = '{1, 1, 1, 8'hEE, 32'h00000000, 4'h0, 0, 0, 0};
      for (int i = 0; i < 14; i++) begin
         step(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d);
         check("tbl_data", 64'(ch_data), 64'(tbl[i].data));
         check("tbl_valid", 64'(ch_valid), 64'(tbl[i].vld));
         check("tbl_done", 64'(frame_done), 64'(tbl[i].done));
         check("tbl_sync", 64'(sync), 64'(tbl[i].sy));
         check("tbl_err", 64'(sof_err), 64'(tbl[i].err));
      end
      step(0, 1, 1, 8'h99);
      check("post_rst_data0", 64'(ch_data[0]), 64'h99);
      check("post_rst_valid", 64'(ch_valid), 64'h1);
      // same frame with two idle cycles between beats
      step(1, 0, 0, 8'h00);
      for (int i = 0; i < NCH; i++) begin
         step(0, 1, i == 0, 8'(8'h11 * (i + 1)));
         for (int g = 0; g < 2; g++) begin
            step(0, 0, 0, 8'($urandom));
            check("gap_valid", 64'(ch_valid), 64'h0);
            check("gap_done", 64'(frame_done), 64'h0);
         end
      end
      check("gap_frame", 64'(ch_data), 64'h44332211);
      // repeated early SOFs drive the error count past saturation
      step(1, 0, 0, 8'h00);
      step(0, 1, 1, 8'h01);
      for (int i = 0; i < 300; i++) step(0, 1, 1, 8'(i));
`ifdef TDM_DEMUX_ERR_CNT_EN
      check("err_cnt_sat", 64'(err_cnt), 64'd255);
`endif
      check("sat_sync", 64'(sync), 64'h1);
      step(1, 0, 0, 8'h00);
      for (int i = 0; i < 3000; i++) begin
         bit r, v, s;
         r = $urandom_range(99) == 0;
         v = $urandom_range(9) < 7;
         s = (m_slot == 0) ? ($urandom_range(19) != 0) : ($urandom_range(9) == 0);
         step(r, v, s, 8'($urandom));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
